// File: rtl/hour_disp_pkg.sv
// Shared types and constants for the hour display driver.
package hour_disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } conv_state_t;

   // Active-low segment patterns, bit order {dp,g,f,e,d,c,b,a}; dp always off.
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;
   localparam logic [7:0] SEG_DASH  = 8'hBF;
   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [5:0] HOUR_MAX = 6'd23;

   // Non-decimal nibbles cannot come out of the converter; blank them anyway.
   function automatic logic [7:0] bcd2seg(input logic [3:0] d);
      logic [7:0] g;
      case (d)
         4'd0:    g = SEG_0;
         4'd1:    g = SEG_1;
         4'd2:    g = SEG_2;
         4'd3:    g = SEG_3;
         4'd4:    g = SEG_4;
         4'd5:    g = SEG_5;
         4'd6:    g = SEG_6;
         4'd7:    g = SEG_7;
         4'd8:    g = SEG_8;
         4'd9:    g = SEG_9;
         default: g = SEG_BLANK;
      endcase
      return g;
   endfunction

endpackage

// File: rtl/hour_disp_drv_bin2bcd_seq.sv
// Sequential 6-bit binary to 2-digit BCD converter (shift-add-3).
//
// state    | meaning
// ST_IDLE  | waiting for start; captures bin_in into val and shift register
// ST_SHIFT | six adjust-and-shift steps, step counts 0..5
// ST_DONE  | scratch holds the result; done is high for this one cycle
module bin2bcd_seq
   import hour_disp_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [5:0] bin_in,
   output logic       busy,
   output logic       done,
   output logic [5:0] val,
   output logic [3:0] tens,
   output logic [3:0] ones
);

   conv_state_t state, state_nxt;
   logic [2:0]  step;
   logic [5:0]  sh;
   logic [7:0]  scr;
   logic [3:0]  adj_t, adj_o;

   // Next-state decode and done strobe.
   always_comb begin
      state_nxt = state;
      done      = 1'b0;
      case (state)
         ST_IDLE:  if (start) state_nxt = ST_SHIFT;
         ST_SHIFT: if (step == 3'd5) state_nxt = ST_DONE;
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Add-3 correction applied to each nibble before it is shifted.
   always_comb begin
      adj_t = (scr[7:4] >= 4'd5) ? scr[7:4] + 4'd3 : scr[7:4];
      adj_o = (scr[3:0] >= 4'd5) ? scr[3:0] + 4'd3 : scr[3:0];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Capture, shift engine and busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val  <= 6'd0;
         sh   <= 6'd0;
         scr  <= 8'd0;
         step <= 3'd0;
         busy <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               val  <= bin_in;
               sh   <= bin_in;
               scr  <= 8'd0;
               step <= 3'd0;
               busy <= 1'b1;
            end
            ST_SHIFT: begin
               {scr, sh} <= {adj_t[2:0], adj_o, sh, 1'b0};
               step      <= step + 3'd1;
            end
            ST_DONE: busy <= 1'b0;
            default: busy <= 1'b0;
         endcase
      end
   end

   assign tens = scr[7:4];
   assign ones = scr[3:0];

endmodule

// File: rtl/hour_disp_drv.sv
// Hour display driver: converts the hour count to BCD and scans two
// common-anode 7-segment digits.
module hour_disp_drv
   import hour_disp_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter bit LZ_BLANK = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] hour_in,
   output logic       busy,
   output logic       err,
   output logic [3:0] bcd_tens,
   output logic [3:0] bcd_ones,
   output logic [1:0] digit_an,
   output logic [7:0] seg
);

   localparam int            CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] TC = CW'(SCAN_DIV - 1);

   logic          start, conv_done;
   logic [5:0]    last_val;
   logic [3:0]    cv_tens, cv_ones;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          idx, idx_nxt;
   logic [7:0]    seg_nxt;

   // Only a value different from the last one captured starts a conversion,
   // so a change made while busy is picked up on the return to idle.
   assign start = (hour_in != last_val);

   bin2bcd_seq u_conv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .bin_in (hour_in),
      .busy   (busy),
      .done   (conv_done),
      .val    (last_val),
      .tens   (cv_tens),
      .ones   (cv_ones)
   );

   // Latch the finished conversion and its range flag together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_tens <= 4'd0;
         bcd_ones <= 4'd0;
         err      <= 1'b0;
      end else if (conv_done) begin
         bcd_tens <= cv_tens;
         bcd_ones <= cv_ones;
         err      <= (last_val > HOUR_MAX);
      end
   end

   // Scan divider and glyph selection for the digit that becomes active.
   always_comb begin
      cnt_nxt = (cnt == TC) ? '0 : cnt + 1'b1;
      idx_nxt = (cnt == TC) ? ~idx : idx;
      if (err)
         seg_nxt = SEG_DASH;
      else if (!idx_nxt)
         seg_nxt = bcd2seg(bcd_ones);
      else if (LZ_BLANK && (bcd_tens == 4'd0))
         seg_nxt = SEG_BLANK;
      else
         seg_nxt = bcd2seg(bcd_tens);
   end

   // Anode and segment registers load on the same edge so they always agree.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         idx      <= 1'b0;
         digit_an <= 2'b10;
         seg      <= SEG_0;
      end else begin
         cnt      <= cnt_nxt;
         idx      <= idx_nxt;
         digit_an <= idx_nxt ? 2'b01 : 2'b10;
         seg      <= seg_nxt;
      end
   end

endmodule
